// File: rtl/ram_rd_check_if.sv
// ram_rd_check_if: RAM port bundle between the read-back checker and the RAM.
//   master : the checker; drives ram_en / ram_we / ram_addr, consumes ram_rd_data
//   slave  : the RAM side; consumes the control/address, returns ram_rd_data
interface ram_rd_check_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rd_data;

   modport master (
      output ram_en,
      output ram_we,
      output ram_addr,
      input  ram_rd_data
   );

   modport slave (
      input  ram_en,
      input  ram_we,
      input  ram_addr,
      output ram_rd_data
   );
endinterface

// File: rtl/ram_rd_check.sv
// ram_rd_check: sweeps addresses 0..DEPTH-1 of the block RAM, compares each
// returned word with (addr + SEED) mod 2^DATA_W, and reports the result.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, abort    : begin a sweep (IDLE only) / cancel a sweep in READ or DRAIN
//   ram             : RAM port (master side), read-only usage
//   busy, done      : not-IDLE flag, one-cycle completion pulse
//   pass, err_cnt   : last sweep clean / mismatch count
//   first_err_addr, first_err_data : location and data of first mismatch
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; RAM port idle, results held
// S_READ  | issuing one read per cycle, addresses 0..DEPTH-1
// S_DRAIN | waiting RD_LAT cycles for the last reads to return
// S_DONE  | one cycle: done pulse, pass becomes valid
module ram_rd_check #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int RD_LAT = 1,
   parameter int SEED   = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   ram_rd_check_if.master      ram,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ADDR_W:0]     err_cnt,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [DATA_W-1:0]   first_err_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [2:0]        DRAIN_LOAD = 3'(RD_LAT - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        drain_cnt;
   logic              read_en;
   logic              abort_hit;
   logic              drain_tc;

   logic [RD_LAT-1:0] pipe_vld;
   logic [ADDR_W-1:0] pipe_addr [RD_LAT];

   logic [31:0]       exp_sum;
   logic [DATA_W-1:0] exp_data;
   logic              mismatch;

   assign read_en   = (state == S_READ);
   assign abort_hit = abort && ((state == S_READ) || (state == S_DRAIN));
   assign drain_tc  = (state == S_DRAIN) && (drain_cnt == 3'd0);

   assign ram.ram_en   = read_en;
   assign ram.ram_we   = 1'b0;
   assign ram.ram_addr = addr_q;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // ---------------- sequencing FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_READ;
                  addr_q <= '0;
               end
            end
            S_READ: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (addr_q == LAST_ADDR) begin
                  state     <= S_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (drain_cnt == 3'd0) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------- compare pipeline ----------------
   // Each stage carries the address of a read in flight; the tail lines up
   // with ram_rd_data returned for that address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
      end else begin
         pipe_vld[0]  <= read_en && !abort_hit;
         pipe_addr[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1] && !abort_hit;
            pipe_addr[i] <= pipe_addr[i-1];
         end
      end
   end

   assign exp_sum  = 32'(pipe_addr[RD_LAT-1]) + 32'(SEED);
   assign exp_data = exp_sum[DATA_W-1:0];
   assign mismatch = pipe_vld[RD_LAT-1] && (ram.ram_rd_data != exp_data);

   // ---------------- result registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass           <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else if ((state == S_IDLE) && start) begin
         pass           <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else begin
         if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) begin
               first_err_addr <= pipe_addr[RD_LAT-1];
               first_err_data <= ram.ram_rd_data;
            end
         end
         // The last compare happens in the final DRAIN cycle, so fold it in
         // here so pass is already valid while done is high.
         if (drain_tc && !abort) begin
            pass <= (err_cnt == '0) && !mismatch;
         end
      end
   end

endmodule

// File: tb/tb_ram_rd_check.sv
module tb_ram_rd_check;
   localparam int AW = 5;
   localparam int DW = 8;
   localparam int DEPTH = 32;
   localparam int LAT_A = 1;
   localparam int SEED_A = 0;
   localparam int LAT_B = 2;
   localparam int SEED_B = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start_a, start_b, abort_a, abort_b;
   int   errors = 0;
   int   checks = 0;

   ram_rd_check_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
   ram_rd_check_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

   logic          a_busy, a_done, a_pass, b_busy, b_done, b_pass;
   logic [AW:0]   a_err, b_err;
   logic [AW-1:0] a_faddr, b_faddr;
   logic [DW-1:0] a_fdata, b_fdata;

   ram_rd_check #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(LAT_A), .SEED(SEED_A)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .ram(if_a.master),
      .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
      .first_err_addr(a_faddr), .first_err_data(a_fdata));

   ram_rd_check #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(LAT_B), .SEED(SEED_B)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .ram(if_b.master),
      .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
      .first_err_addr(b_faddr), .first_err_data(b_fdata));

   // RAM models: a read issued in cycle t returns data in cycle t+latency
   logic [7:0] mem_a [32];
   logic [7:0] mem_b [32];
   logic [7:0] rp_a;
   logic [7:0] rp_b0, rp_b1;

   always @(posedge clk) if (if_a.ram_en) rp_a <= mem_a[if_a.ram_addr];
   always @(posedge clk) begin
      if (if_b.ram_en) rp_b0 <= mem_b[if_b.ram_addr];
      rp_b1 <= rp_b0;
   end
   assign if_a.ram_rd_data = rp_a;
   assign if_b.ram_rd_data = rp_b1;

   // observation mux over the two instances
   int            sel;
   logic          o_en, o_we, o_busy, o_done, o_pass;
   logic [AW:0]   o_err;
   logic [AW-1:0] o_addr, o_faddr;
   logic [DW-1:0] o_fdata;
   always_comb begin
      o_en = if_a.ram_en; o_we = if_a.ram_we; o_addr = if_a.ram_addr;
      o_busy = a_busy; o_done = a_done; o_pass = a_pass;
      o_err = a_err; o_faddr = a_faddr; o_fdata = a_fdata;
      if (sel == 1) begin
         o_en = if_b.ram_en; o_we = if_b.ram_we; o_addr = if_b.ram_addr;
         o_busy = b_busy; o_done = b_done; o_pass = b_pass;
         o_err = b_err; o_faddr = b_faddr; o_fdata = b_fdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: mismatch count and first mismatch straight from the RAM image
   function automatic void model(input int inst, output int err, output int faddr, output int fdata);
      err = 0; faddr = 0; fdata = 0;
      for (int a = 0; a < DEPTH; a++) begin
         int   seed;
         logic [7:0] got;
         seed = (inst == 1) ? SEED_B : SEED_A;
         got  = (inst == 1) ? mem_b[a] : mem_a[a];
         if (got != 8'((a + seed) % 256)) begin
            if (err == 0) begin faddr = a; fdata = int'(got); end
            err++;
         end
      end
   endfunction

   task automatic fill(input int inst, input int seed);
      for (int a = 0; a < DEPTH; a++) begin
         if (inst == 1) mem_b[a] = 8'((a + seed) % 256);
         else           mem_a[a] = 8'((a + seed) % 256);
      end
   endtask

   // Runs one sweep from a start pulse; returns in cycle exp_lat+2 relative to start edge.
   task automatic sweep(input int inst, input bit ign, input int exp_lat,
                        input int exp_err, input int exp_faddr, input int exp_fdata);
      int cyc, dcnt, dcyc;
      logic addr_ok, busy_at_done, busy_after;
      logic r_pass;
      logic [AW:0] r_err;
      logic [AW-1:0] r_fa;
      logic [DW-1:0] r_fd;
      sel = inst;
      if (inst == 1) start_b = 1'b1; else start_a = 1'b1;
      step();
      start_a = 1'b0; start_b = 1'b0;
      cyc = 1; dcnt = 0; dcyc = -1; addr_ok = 1'b1;
      busy_at_done = 1'bx; busy_after = 1'bx;
      r_pass = 1'bx; r_err = 'x; r_fa = 'x; r_fd = 'x;
      forever begin
         if (cyc <= DEPTH) begin
            if (o_en !== 1'b1 || o_we !== 1'b0 || o_addr !== 5'(cyc - 1) || o_busy !== 1'b1)
               addr_ok = 1'b0;
         end else if (o_en !== 1'b0 || o_we !== 1'b0) begin
            addr_ok = 1'b0;
         end
         if (o_done === 1'b1) begin
            dcnt++; dcyc = cyc;
            r_pass = o_pass; r_err = o_err; r_fa = o_faddr; r_fd = o_fdata;
         end
         if (cyc == exp_lat)     busy_at_done = o_busy;
         if (cyc == exp_lat + 1) busy_after   = o_busy;
         if (cyc == exp_lat + 2) break;
         if (ign && (cyc == 10 || cyc == 34)) begin
            if (inst == 1) start_b = 1'b1; else start_a = 1'b1;
         end
         step();
         start_a = 1'b0; start_b = 1'b0;
         cyc++;
      end
      chk("addr_seq", 32'(addr_ok), 32'd1);
      chk("done_count", dcnt, 1);
      chk("done_cycle", dcyc, exp_lat);
      chk("busy_at_done", 32'(busy_at_done), 32'd1);
      chk("busy_after_done", 32'(busy_after), 32'd0);
      chk("pass", 32'(r_pass), 32'(exp_err == 0));
      chk("err_cnt", 32'(r_err), exp_err);
      chk("first_err_addr", 32'(r_fa), exp_faddr);
      chk("first_err_data", 32'(r_fd), exp_fdata);
      chk("pass_hold", 32'(o_pass), 32'(exp_err == 0));
      chk("err_hold", 32'(o_err), exp_err);
   endtask

   initial begin
      int e, fa, fd, n, cyc, dcnt;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
      sel = 0;
      fill(0, 0); fill(1, SEED_B);
      step(); step();
      // reset values
      chk("rst_en", 32'(if_a.ram_en), 0);
      chk("rst_we", 32'(if_a.ram_we), 0);
      chk("rst_addr", 32'(if_a.ram_addr), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_pass", 32'(a_pass), 0);
      chk("rst_err", 32'(a_err), 0);
      chk("rst_b_busy", 32'(b_busy), 0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // clean sweep, defaults
      fill(0, 0);
      sweep(0, 1'b0, 34, 0, 0, 0);

      // words 5 and 17 corrupted
      mem_a[5] = 8'hFF; mem_a[17] = 8'hFF;
      sweep(0, 1'b0, 34, 2, 5, 8'hFF);

      // RD_LAT=2, SEED=0x10, RAM holds addr+0x10
      fill(1, 16);
      sweep(1, 1'b0, 35, 0, 0, 0);

      // same contents checked with SEED=0
      fill(0, 16);
      sweep(0, 1'b0, 34, 32, 0, 8'h10);

      // start re-pulsed at cycles 10 and 34, then a second sweep 2 cycles after done
      fill(0, 0);
      sweep(0, 1'b1, 34, 0, 0, 0);
      sweep(0, 1'b0, 34, 0, 0, 0);

      // abort at cycle 12 with a corrupt word at address 3
      sel = 0;
      mem_a[3] = 8'hAA;
      start_a = 1'b1; step(); start_a = 1'b0;
      for (cyc = 1; cyc < 12; cyc++) step();
      abort_a = 1'b1; step(); abort_a = 1'b0;
      chk("abort_busy", 32'(a_busy), 0);
      chk("abort_en", 32'(if_a.ram_en), 0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (a_done === 1'b1) dcnt++;
         step();
      end
      chk("abort_no_done", dcnt, 0);
      chk("abort_err", 32'(a_err), 1);
      chk("abort_pass", 32'(a_pass), 0);
      chk("abort_faddr", 32'(a_faddr), 3);
      chk("abort_fdata", 32'(a_fdata), 8'hAA);

      // asynchronous reset at cycle 20 mid-sweep
      fill(0, 0); mem_a[2] = 8'h55;
      start_a = 1'b1; step(); start_a = 1'b0;
      for (cyc = 1; cyc < 20; cyc++) step();
      chk("pre_rst_err", 32'(a_err), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en", 32'(if_a.ram_en), 0);
      chk("arst_addr", 32'(if_a.ram_addr), 0);
      chk("arst_busy", 32'(a_busy), 0);
      chk("arst_done", 32'(a_done), 0);
      chk("arst_pass", 32'(a_pass), 0);
      chk("arst_err", 32'(a_err), 0);
      chk("arst_faddr", 32'(a_faddr), 0);
      chk("arst_fdata", 32'(a_fdata), 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      fill(0, 0);
      sweep(0, 1'b0, 34, 0, 0, 0);

      // randomized corruption against the reference model
      for (int it = 0; it < 4; it++) begin
         fill(0, 0);
         n = $urandom_range(0, 4);
         for (int j = 0; j < n; j++) mem_a[$urandom_range(0, DEPTH - 1)] = 8'($urandom_range(0, 255));
         model(0, e, fa, fd);
         sweep(0, 1'b0, 34, e, fa, fd);
      end
      for (int it = 0; it < 2; it++) begin
         fill(1, SEED_B);
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) mem_b[$urandom_range(0, DEPTH - 1)] = 8'($urandom_range(0, 255));
         model(1, e, fa, fd);
         sweep(1, 1'b0, 35, e, fa, fd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
